// File: rtl/pc_redirect.sv
// Fetch-PC sequencer with EX-stage redirect for branches, JAL and JALR.
// A taken transfer flushes IF/ID and ID/EX for two cycles; branch and redirect counters are kept for profiling.
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_jal_i,
    input  logic        ex_is_jalr_i,
    input  logic        br_f_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic [31:0] alu_c_i,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] link_o,
    output logic        misalign_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] taken_cnt_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    logic        accept;
    logic        take;
    logic [31:0] target;

    // The instruction in EX during FLUSH is already dead, so it can neither redirect nor count.
    assign accept = ex_valid_i & (state_q == RUN);
    assign take   = accept & (ex_is_jal_i | ex_is_jalr_i | (ex_is_br_i & br_f_i));
    assign target = ex_is_jalr_i ? (alu_c_i & ~32'h1) : (ex_pc_i + ex_imm_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q + 32'd4;
        misalign_d  = misalign_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;

        case (state_q)
            RUN:     state_d = take ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase

        if (take) begin
            pc_d = target;
        end else if (stall_i) begin
            pc_d = pc_q;
        end

        if (take && target[1]) begin
            misalign_d = 1'b1;
        end
        if (accept && ex_is_br_i) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (take) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            misalign_q  <= 1'b0;
            br_cnt_q    <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            misalign_q  <= misalign_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Masking with rst_i keeps the combinational outputs quiet while reset is held.
    assign redirect_o  = take & ~rst_i;
    assign flush_o     = (take | (state_q == FLUSH)) & ~rst_i;
    assign link_o      = ex_pc_i + 32'd4;
    assign pc_o        = pc_q;
    assign misalign_o  = misalign_q;
    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: a vector table walked cycle by cycle, plus
// hand-written sequences for reset masking and an asynchronous reset during FLUSH.
module tb_pc_redirect;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exValid;
    logic        exIsBr;
    logic        exIsJal;
    logic        exIsJalr;
    logic        brF;
    logic [31:0] exPc;
    logic [31:0] exImm;
    logic [31:0] aluC;
    logic [31:0] pc;
    logic        flush;
    logic        redirect;
    logic [31:0] link;
    logic        misalign;
    logic [31:0] brCnt;
    logic [31:0] takenCnt;

    int compared   = 0;
    int mismatched = 0;

    pc_redirect dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .ex_valid_i  (exValid),
        .ex_is_br_i  (exIsBr),
        .ex_is_jal_i (exIsJal),
        .ex_is_jalr_i(exIsJalr),
        .br_f_i      (brF),
        .ex_pc_i     (exPc),
        .ex_imm_i    (exImm),
        .alu_c_i     (aluC),
        .pc_o        (pc),
        .flush_o     (flush),
        .redirect_o  (redirect),
        .link_o      (link),
        .misalign_o  (misalign),
        .br_cnt_o    (brCnt),
        .taken_cnt_o (takenCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs for one cycle, expected same-cycle outputs, expected state after the edge.
    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        brF;
        logic [31:0] exPc;
        logic [31:0] exImm;
        logic [31:0] aluC;
        logic        expRedirect;
        logic        expFlush;
        logic [31:0] expLink;
        logic [31:0] expPc;
        logic [31:0] expBrCnt;
        logic [31:0] expTakenCnt;
        logic        expMisalign;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic b, input logic j,
                                 input logic jr, input logic f, input logic [31:0] p,
                                 input logic [31:0] i, input logic [31:0] a);
        stall    = s;
        exValid  = v;
        exIsBr   = b;
        exIsJal  = j;
        exIsJalr = jr;
        brF      = f;
        exPc     = p;
        exImm    = i;
        aluC     = a;
    endtask

    initial begin
        // name, stall, valid, br, jal, jalr, brF, exPc, exImm, aluC, redirect, flush, link, pc, brCnt, takenCnt, misalign
        vecs.push_back('{"idle0",      0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,0, 32'h4,        32'h4,        0,0,0});
        vecs.push_back('{"idle1",      0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,0, 32'h4,        32'h8,        0,0,0});
        vecs.push_back('{"idle2",      0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,0, 32'h4,        32'hC,        0,0,0});
        vecs.push_back('{"brNotTaken", 0,1,1,0,0,0, 32'h40,       32'h20,       32'h0,    0,0, 32'h44,       32'h10,       1,0,0});
        vecs.push_back('{"brTaken",    0,1,1,0,0,1, 32'h100,      32'hFFFFFFF0, 32'h0,    1,1, 32'h104,      32'hF0,       2,1,0});
        vecs.push_back('{"brInFlush",  0,1,1,0,0,1, 32'h100,      32'hFFFFFFF0, 32'h0,    0,1, 32'h104,      32'hF4,       2,1,0});
        vecs.push_back('{"afterFlush", 0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,0, 32'h4,        32'hF8,       2,1,0});
        vecs.push_back('{"jalrStall",  1,1,0,0,1,0, 32'h300,      32'h0,        32'h203,  1,1, 32'h304,      32'h202,      2,2,1});
        vecs.push_back('{"stallFlush", 1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,1, 32'h4,        32'h202,      2,2,1});
        vecs.push_back('{"jalFirst",   0,1,0,1,0,0, 32'h400,      32'h10,       32'h0,    1,1, 32'h404,      32'h410,      2,3,1});
        vecs.push_back('{"jalSecond",  0,1,0,1,0,0, 32'h404,      32'h100,      32'h0,    0,1, 32'h408,      32'h414,      2,3,1});
        vecs.push_back('{"multiFlag",  0,1,1,1,1,1, 32'h500,      32'h8,        32'h1001, 1,1, 32'h504,      32'h1000,     3,4,1});
        vecs.push_back('{"multiFlush", 0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,1, 32'h4,        32'h1004,     3,4,1});
        vecs.push_back('{"notValid",   0,0,1,1,0,1, 32'h600,      32'h40,       32'h0,    0,0, 32'h604,      32'h1008,     3,4,1});
        vecs.push_back('{"jalWrapTgt", 0,1,0,1,0,0, 32'hFFFFFFF0, 32'h20,       32'h0,    1,1, 32'hFFFFFFF4, 32'h10,       3,5,1});
        vecs.push_back('{"wrapFlush",  0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,1, 32'h4,        32'h14,       3,5,1});
        vecs.push_back('{"jalToTop",   0,1,0,1,0,0, 32'h0,        32'hFFFFFFFC, 32'h0,    1,1, 32'h4,        32'hFFFFFFFC, 3,6,1});
        vecs.push_back('{"pcWrap",     0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0,1, 32'h4,        32'h0,        3,6,1});

        // Reset held with a JAL on the inputs: redirect and flush must stay masked.
        rst = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h80, 32'h40, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstRedirect", {31'd0, redirect}, 32'd0);
        checkOutput("rstFlush",    {31'd0, flush},    32'd0);
        checkOutput("rstPc",       pc,                32'h0);
        checkOutput("rstBrCnt",    brCnt,             32'd0);
        checkOutput("rstTakenCnt", takenCnt,          32'd0);
        checkOutput("rstMisalign", {31'd0, misalign}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("relPc", pc, 32'h0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].stall, vecs[k].valid, vecs[k].br, vecs[k].jal, vecs[k].jalr,
                          vecs[k].brF, vecs[k].exPc, vecs[k].exImm, vecs[k].aluC);
            #1;
            checkOutput({vecs[k].name, ".redirect"}, {31'd0, redirect}, {31'd0, vecs[k].expRedirect});
            checkOutput({vecs[k].name, ".flush"},    {31'd0, flush},    {31'd0, vecs[k].expFlush});
            checkOutput({vecs[k].name, ".link"},     link,              vecs[k].expLink);
            @(posedge clk);
            #1;
            checkOutput({vecs[k].name, ".pc"},       pc,                vecs[k].expPc);
            checkOutput({vecs[k].name, ".brCnt"},    brCnt,             vecs[k].expBrCnt);
            checkOutput({vecs[k].name, ".takenCnt"}, takenCnt,          vecs[k].expTakenCnt);
            checkOutput({vecs[k].name, ".misalign"}, {31'd0, misalign}, {31'd0, vecs[k].expMisalign});
        end

        // JAL enters FLUSH, then reset is pulsed between edges.
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h700, 32'h80, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("preRstPc",    pc,                32'h780);
        checkOutput("preRstFlush", {31'd0, flush},    32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstPc",       pc,                32'h0);
        checkOutput("asyncRstFlush",    {31'd0, flush},    32'd0);
        checkOutput("asyncRstBrCnt",    brCnt,             32'd0);
        checkOutput("asyncRstTakenCnt", takenCnt,          32'd0);
        checkOutput("asyncRstMisalign", {31'd0, misalign}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postRstFlush", {31'd0, flush}, 32'd0);
        checkOutput("postRstPc",    pc,             32'h0);
        @(posedge clk);
        #1;
        checkOutput("postRstPcNext", pc,             32'h4);
        checkOutput("postRstFlush2", {31'd0, flush}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 stall_i  input  1  hold fetch PC (load-use hazard from ID).
REQ-005 ex_valid_i  input  1  EX stage holds a real instruction.
REQ-006 ex_is_br_i  input  1  EX instruction is a conditional branch.
REQ-007 ex_is_jal_i  input  1  EX instruction is JAL.
REQ-008 ex_is_jalr_i  input  1  EX instruction is JALR.
REQ-009 br_f_i  input  1  ALU branch-taken flag for the EX instruction.
REQ-010 ex_pc_i  input  32  PC of the EX instruction.
REQ-011 ex_imm_i  input  32  sign-extended immediate of the EX instruction.
REQ-012 alu_c_i  input  32  ALU result (rs1 + imm for JALR).
REQ-013 pc_o  output  32  current fetch PC (registered).
REQ-014 flush_o  output  1  kill IF/ID and ID/EX contents at the next edge.
REQ-015 redirect_o  output  1  taken control transfer accepted this cycle.
REQ-016 link_o  output  32  ex_pc_i + 4, rd value for JAL/JALR.
REQ-017 misalign_o  output  1  sticky: a redirect target had bit 1 set.
REQ-018 br_cnt_o  output  32  count of accepted conditional branches.
REQ-019 taken_cnt_o  output  32  count of accepted redirects (branches taken, JAL, JALR).

Function
REQ-020 take = accept & (ex_is_jal_i | ex_is_jalr_i | (ex_is_br_i & br_f_i)), where accept = ex_valid_i & (state == RUN).
REQ-021 Target: JALR -> alu_c_i & ~32'h1; JAL or branch -> ex_pc_i + ex_imm_i, 32-bit wrap-around, carry discarded.
REQ-022 redirect_o = take, combinational, same cycle as the EX inputs.
REQ-023 Next pc_o priority: take -> target; else stall_i -> hold; else pc_o + 4 (wraps 32'hFFFF_FFFC -> 0).
REQ-024 take with stall_i simultaneously: the redirect wins and the stall is discarded.
REQ-025 FSM states RUN and FLUSH; RUN -> FLUSH on take; FLUSH -> RUN unconditionally after one cycle.
REQ-026 flush_o = take | (state == FLUSH): asserted for exactly two consecutive cycles per redirect.
REQ-027 In FLUSH, EX inputs are ignored: no redirect, no counter update; pc_o advances by +4 from the target unless stall_i is set.
REQ-028 Multiple type flags set at once: JALR > JAL > branch for target selection; counted once.
REQ-029 br_cnt_o increments when accept & ex_is_br_i, whether or not the branch is taken.
REQ-030 taken_cnt_o increments on take; both counters wrap at 2^32.
REQ-031 misalign_o sets when take and target[1] == 1; cleared only by reset; the redirect still occurs.
REQ-032 link_o is combinational, 32-bit wrap-around, valid regardless of state.
REQ-033 Latency: target appears on pc_o one cycle after take.

Reset
REQ-034 While rst_i is high: pc_o = RESET_PC, state = RUN, flush_o = 0, misalign_o = 0, br_cnt_o = 0, taken_cnt_o = 0; redirect_o is masked to 0.
REQ-035 Reset asserted mid-FLUSH aborts the flush; the first cycle after release is RUN with pc_o = RESET_PC.
REQ-036 No output shows X after reset; combinational outputs derive only from reset state and inputs.

Verification
REQ-037 Reset released, no stall, 4 cycles -> pc_o sequence 0, 4, 8, 12; flush_o = 0 throughout.
REQ-038 Branch taken: ex_pc_i = 0x100, ex_imm_i = 0xFFFFFFF0, br_f_i = 1 -> redirect_o = 1; next pc_o = 0xF0; flush_o high 2 cycles; taken_cnt_o = 1; br_cnt_o = 1.
REQ-039 Branch not taken, br_f_i = 0 -> pc_o continues +4; br_cnt_o = 1; taken_cnt_o = 0; flush_o = 0.
REQ-040 JALR: alu_c_i = 0x203, stall_i = 1 in the same cycle -> next pc_o = 0x202; misalign_o = 1; link_o = ex_pc_i + 4.
REQ-041 JAL in cycle t, JAL presented again at t+1 (FLUSH) -> only the first redirects; taken_cnt_o = 1; pc_o at t+2 = target + 4.
REQ-042 rst_i pulsed asynchronously between edges during FLUSH -> pc_o = RESET_PC immediately; flush_o = 0; counters = 0.
